// File: rtl/issue_scoreboard_if.sv
// ID-stage issue bundle for the dual-issue scoreboard: ID pair, EX squash,
// WB retire, and the stall / pending / counter results.
interface issue_scoreboard_if #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int SCW  = 32
);
    logic            ID_valid_a, ID_valid_b;
    logic [AW-1:0]   ID_rf_raddr_a1, ID_rf_raddr_a2, ID_rf_raddr_b1, ID_rf_raddr_b2;
    logic [AW-1:0]   ID_rf_waddr_a, ID_rf_waddr_b;
    logic            ID_rf_we_a, ID_rf_we_b;
    logic            ID_long_a, ID_long_b;
    logic            EX_stall;
    logic            EX_kill_b;
    logic [AW-1:0]   EX_rf_waddr_b;
    logic            EX_long_b;
    logic            WB_rf_we_a, WB_rf_we_b, WB_long_a, WB_long_b;
    logic [AW-1:0]   WB_rf_waddr_a, WB_rf_waddr_b;
    logic            ID_stall;
    logic [NREG-1:0] pending_vec;
    logic [SCW-1:0]  stall_cnt;

    modport master (
        output ID_valid_a, ID_valid_b, ID_rf_raddr_a1, ID_rf_raddr_a2,
               ID_rf_raddr_b1, ID_rf_raddr_b2, ID_rf_waddr_a, ID_rf_waddr_b,
               ID_rf_we_a, ID_rf_we_b, ID_long_a, ID_long_b, EX_stall,
               EX_kill_b, EX_rf_waddr_b, EX_long_b,
               WB_rf_we_a, WB_rf_we_b, WB_long_a, WB_long_b,
               WB_rf_waddr_a, WB_rf_waddr_b,
        input  ID_stall, pending_vec, stall_cnt
    );

    modport slave (
        input  ID_valid_a, ID_valid_b, ID_rf_raddr_a1, ID_rf_raddr_a2,
               ID_rf_raddr_b1, ID_rf_raddr_b2, ID_rf_waddr_a, ID_rf_waddr_b,
               ID_rf_we_a, ID_rf_we_b, ID_long_a, ID_long_b, EX_stall,
               EX_kill_b, EX_rf_waddr_b, EX_long_b,
               WB_rf_we_a, WB_rf_we_b, WB_long_a, WB_long_b,
               WB_rf_waddr_a, WB_rf_waddr_b,
        output ID_stall, pending_vec, stall_cnt
    );
endinterface

// File: rtl/issue_scoreboard.sv
// Dual-issue register scoreboard: tracks outstanding long-latency destinations
// and stalls the ID pair on RAW or long-long WAW collisions.
module issue_scoreboard #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int SCW  = 32
) (
    input logic               clk,
    input logic               rstn,
    issue_scoreboard_if.slave sb
);

    logic [NREG-1:0] clear_vec;
    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] eff_pending;
    logic [NREG-1:0] pending_next;
    logic            hazard_a, hazard_b;
    logic            any_valid;
    logic            accept;

    function automatic logic slot_hazard(
        input logic            valid,
        input logic [AW-1:0]   src1,
        input logic [AW-1:0]   src2,
        input logic            we,
        input logic            is_long,
        input logic [AW-1:0]   dst,
        input logic [NREG-1:0] eff
    );
        logic hit;
        hit = 1'b0;
        if (src1 != '0 && eff[src1]) hit = 1'b1;
        if (src2 != '0 && eff[src2]) hit = 1'b1;
        if (we && is_long && dst != '0 && eff[dst]) hit = 1'b1;
        return valid & hit;
    endfunction

    // Retiring long results and squashed slot-B producers release their register this cycle.
    always_comb begin
        clear_vec = '0;
        if (sb.WB_rf_we_a && sb.WB_long_a) clear_vec[sb.WB_rf_waddr_a] = 1'b1;
        if (sb.WB_rf_we_b && sb.WB_long_b) clear_vec[sb.WB_rf_waddr_b] = 1'b1;
        if (sb.EX_kill_b && sb.EX_long_b)  clear_vec[sb.EX_rf_waddr_b] = 1'b1;
    end

    assign eff_pending = sb.pending_vec & ~clear_vec;

    assign hazard_a = slot_hazard(sb.ID_valid_a, sb.ID_rf_raddr_a1, sb.ID_rf_raddr_a2,
                                  sb.ID_rf_we_a, sb.ID_long_a, sb.ID_rf_waddr_a, eff_pending);
    assign hazard_b = slot_hazard(sb.ID_valid_b, sb.ID_rf_raddr_b1, sb.ID_rf_raddr_b2,
                                  sb.ID_rf_we_b, sb.ID_long_b, sb.ID_rf_waddr_b, eff_pending);

    assign any_valid   = sb.ID_valid_a | sb.ID_valid_b;
    assign sb.ID_stall = hazard_a | hazard_b | sb.EX_stall;
    assign accept      = ~sb.ID_stall & any_valid;

    always_comb begin
        set_vec = '0;
        if (accept) begin
            if (sb.ID_valid_a && sb.ID_rf_we_a && sb.ID_long_a) set_vec[sb.ID_rf_waddr_a] = 1'b1;
            if (sb.ID_valid_b && sb.ID_rf_we_b && sb.ID_long_b) set_vec[sb.ID_rf_waddr_b] = 1'b1;
        end
    end

    // Set is applied after clear so a new producer wins over a same-cycle retire.
    assign pending_next = (sb.pending_vec & ~clear_vec) | set_vec;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sb.pending_vec <= '0;
        end else begin
            sb.pending_vec <= {pending_next[NREG-1:1], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sb.stall_cnt <= '0;
        end else if (any_valid && sb.ID_stall && !(&sb.stall_cnt)) begin
            sb.stall_cnt <= sb.stall_cnt + SCW'(1);
        end
    end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Randomized and directed bench for issue_scoreboard against a set-based
// reference model of outstanding long-latency destinations.
module tb_issue_scoreboard;

    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int SCW  = 32;

    logic clk;
    logic rstn;

    issue_scoreboard_if #(.NREG(NREG), .AW(AW), .SCW(SCW)) m ();
    issue_scoreboard_if #(.NREG(NREG), .AW(AW), .SCW(4))   m4 ();

    issue_scoreboard #(.NREG(NREG), .AW(AW), .SCW(SCW)) dut (
        .clk (clk),
        .rstn(rstn),
        .sb  (m.slave)
    );

    issue_scoreboard #(.NREG(NREG), .AW(AW), .SCW(4)) dut4 (
        .clk (clk),
        .rstn(rstn),
        .sb  (m4.slave)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    bit          model_pend[NREG];
    longint      model_cnt;
    bit          exp_stall;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        else
            n_pass++;
    endtask

    function automatic logic [31:0] packModel();
        logic [31:0] v;
        v = '0;
        for (int r = 0; r < NREG; r++) v[r] = model_pend[r];
        return v;
    endfunction

    function automatic bit slotHits(input bit v, input int s1, input int s2, input bit we,
                                    input bit lng, input int d, input bit busy[NREG]);
        if (!v) return 1'b0;
        if (s1 != 0 && busy[s1]) return 1'b1;
        if (s2 != 0 && busy[s2]) return 1'b1;
        if (we && lng && d != 0 && busy[d]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic idleInputs();
        m.ID_valid_a = 0; m.ID_valid_b = 0;
        m.ID_rf_raddr_a1 = 0; m.ID_rf_raddr_a2 = 0; m.ID_rf_raddr_b1 = 0; m.ID_rf_raddr_b2 = 0;
        m.ID_rf_waddr_a = 0; m.ID_rf_waddr_b = 0; m.ID_rf_we_a = 0; m.ID_rf_we_b = 0;
        m.ID_long_a = 0; m.ID_long_b = 0; m.EX_stall = 0;
        m.EX_kill_b = 0; m.EX_rf_waddr_b = 0; m.EX_long_b = 0;
        m.WB_rf_we_a = 0; m.WB_rf_we_b = 0; m.WB_long_a = 0; m.WB_long_b = 0;
        m.WB_rf_waddr_a = 0; m.WB_rf_waddr_b = 0;
    endtask

    task automatic idleInputs4();
        m4.ID_valid_a = 0; m4.ID_valid_b = 0;
        m4.ID_rf_raddr_a1 = 0; m4.ID_rf_raddr_a2 = 0; m4.ID_rf_raddr_b1 = 0; m4.ID_rf_raddr_b2 = 0;
        m4.ID_rf_waddr_a = 0; m4.ID_rf_waddr_b = 0; m4.ID_rf_we_a = 0; m4.ID_rf_we_b = 0;
        m4.ID_long_a = 0; m4.ID_long_b = 0; m4.EX_stall = 0;
        m4.EX_kill_b = 0; m4.EX_rf_waddr_b = 0; m4.EX_long_b = 0;
        m4.WB_rf_we_a = 0; m4.WB_rf_we_b = 0; m4.WB_long_a = 0; m4.WB_long_b = 0;
        m4.WB_rf_waddr_a = 0; m4.WB_rf_waddr_b = 0;
    endtask

    // Inputs are set just after a falling edge; check stall, clock, then check state.
    task automatic applyStimulus();
        bit busy[NREG];
        bit acc;
        bit any_v;
        busy = model_pend;
        if (m.WB_rf_we_a && m.WB_long_a) busy[m.WB_rf_waddr_a] = 1'b0;
        if (m.WB_rf_we_b && m.WB_long_b) busy[m.WB_rf_waddr_b] = 1'b0;
        if (m.EX_kill_b && m.EX_long_b)  busy[m.EX_rf_waddr_b] = 1'b0;
        exp_stall = m.EX_stall
                  | slotHits(m.ID_valid_a, m.ID_rf_raddr_a1, m.ID_rf_raddr_a2, m.ID_rf_we_a,
                             m.ID_long_a, m.ID_rf_waddr_a, busy)
                  | slotHits(m.ID_valid_b, m.ID_rf_raddr_b1, m.ID_rf_raddr_b2, m.ID_rf_we_b,
                             m.ID_long_b, m.ID_rf_waddr_b, busy);
        any_v = m.ID_valid_a | m.ID_valid_b;
        acc = !exp_stall && any_v;
        #1;
        checkOutput("id_stall", 64'(m.ID_stall), 64'(exp_stall));
        @(posedge clk);
        model_pend = busy;
        if (acc) begin
            if (m.ID_valid_a && m.ID_rf_we_a && m.ID_long_a && m.ID_rf_waddr_a != 0)
                model_pend[m.ID_rf_waddr_a] = 1'b1;
            if (m.ID_valid_b && m.ID_rf_we_b && m.ID_long_b && m.ID_rf_waddr_b != 0)
                model_pend[m.ID_rf_waddr_b] = 1'b1;
        end
        if (any_v && exp_stall && model_cnt < 64'hFFFF_FFFF) model_cnt++;
        #1;
        checkOutput("pending_vec", 64'(m.pending_vec), 64'(packModel()));
        checkOutput("stall_cnt", 64'(m.stall_cnt), 64'(model_cnt));
    endtask

    task automatic modelReset();
        for (int r = 0; r < NREG; r++) model_pend[r] = 1'b0;
        model_cnt = 0;
    endtask

    task automatic doReset();
        rstn = 1'b0;
        modelReset();
        #3;
        checkOutput("rst_pending", 64'(m.pending_vec), 64'd0);
        checkOutput("rst_cnt", 64'(m.stall_cnt), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic longWriteA(input int d);
        @(negedge clk); idleInputs();
        m.ID_valid_a = 1; m.ID_rf_we_a = 1; m.ID_long_a = 1; m.ID_rf_waddr_a = AW'(d);
        applyStimulus();
    endtask

    task automatic readA(input int s);
        @(negedge clk); idleInputs();
        m.ID_valid_a = 1; m.ID_rf_raddr_a1 = AW'(s);
        applyStimulus();
    endtask

    task automatic randomCycle();
        int q[$];
        @(negedge clk); idleInputs();
        for (int r = 1; r < NREG; r++) if (model_pend[r]) q.push_back(r);
        m.ID_valid_a = 1'($urandom_range(0, 3) != 0);
        m.ID_valid_b = 1'($urandom_range(0, 2) != 0);
        m.ID_rf_raddr_a1 = AW'($urandom_range(0, 7)); m.ID_rf_raddr_a2 = AW'($urandom_range(0, 7));
        m.ID_rf_raddr_b1 = AW'($urandom_range(0, 7)); m.ID_rf_raddr_b2 = AW'($urandom_range(0, 7));
        m.ID_rf_waddr_a = AW'($urandom_range(0, 7)); m.ID_rf_waddr_b = AW'($urandom_range(0, 7));
        m.ID_rf_we_a = 1'($urandom); m.ID_rf_we_b = 1'($urandom);
        m.ID_long_a = 1'($urandom); m.ID_long_b = 1'($urandom);
        if (m.ID_long_a && m.ID_long_b && m.ID_rf_waddr_a == m.ID_rf_waddr_b) m.ID_long_a = 0;
        m.EX_stall = 1'($urandom_range(0, 5) == 0);
        if (q.size() != 0) begin
            m.WB_rf_we_a = 1'($urandom); m.WB_long_a = 1'b1;
            m.WB_rf_waddr_a = AW'(q[$urandom_range(0, q.size() - 1)]);
            m.WB_rf_we_b = 1'($urandom_range(0, 3) == 0); m.WB_long_b = 1'($urandom);
            m.WB_rf_waddr_b = AW'(q[$urandom_range(0, q.size() - 1)]);
            m.EX_kill_b = 1'($urandom_range(0, 5) == 0); m.EX_long_b = 1'b1;
            m.EX_rf_waddr_b = AW'(q[$urandom_range(0, q.size() - 1)]);
        end
        applyStimulus();
    endtask

    initial begin
        idleInputs();
        idleInputs4();
        modelReset();
        rstn = 1'b0;
        #2;
        doReset();
        #1;
        checkOutput("idle_stall", 64'(m.ID_stall), 64'd0);

        // Load-use: r5 produced long, consumer waits until the WB cycle.
        longWriteA(5);
        readA(5);
        checkOutput("lu_stall_c1", 64'(exp_stall), 64'd1);
        readA(5);
        readA(5);
        @(negedge clk); idleInputs();
        m.ID_valid_a = 1; m.ID_rf_raddr_a1 = 5;
        m.WB_rf_we_a = 1; m.WB_long_a = 1; m.WB_rf_waddr_a = 5;
        applyStimulus();
        checkOutput("lu_released", 64'(m.pending_vec[5]), 64'd0);

        // WAW: long write to pending r7 stalls, short write does not.
        longWriteA(7);
        @(negedge clk); idleInputs();
        m.ID_valid_b = 1; m.ID_rf_we_b = 1; m.ID_long_b = 1; m.ID_rf_waddr_b = 7;
        applyStimulus();
        @(negedge clk); idleInputs();
        m.ID_valid_b = 1; m.ID_rf_we_b = 1; m.ID_long_b = 0; m.ID_rf_waddr_b = 7;
        applyStimulus();
        checkOutput("waw_short_keeps", 64'(m.pending_vec[7]), 64'd1);

        // Set/clear collision on r9.
        longWriteA(9);
        @(negedge clk); idleInputs();
        m.ID_valid_a = 1; m.ID_rf_we_a = 1; m.ID_long_a = 1; m.ID_rf_waddr_a = 9;
        m.WB_rf_we_a = 1; m.WB_long_a = 1; m.WB_rf_waddr_a = 9;
        applyStimulus();
        checkOutput("setclr_r9", 64'(m.pending_vec[9]), 64'd1);

        // Kill of slot B clears r12; long write to r0 is ignored.
        longWriteA(12);
        @(negedge clk); idleInputs();
        m.EX_kill_b = 1; m.EX_long_b = 1; m.EX_rf_waddr_b = 12;
        applyStimulus();
        checkOutput("kill_r12", 64'(m.pending_vec[12]), 64'd0);
        longWriteA(0);
        checkOutput("r0_never", 64'(m.pending_vec[0]), 64'd0);

        // Counter: 5 valid stalled cycles, then invalid stalled cycles.
        @(negedge clk);
        doReset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); idleInputs();
            m.ID_valid_a = 1; m.EX_stall = 1;
            applyStimulus();
        end
        checkOutput("cnt_five", 64'(m.stall_cnt), 64'd5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); idleInputs();
            m.EX_stall = 1;
            applyStimulus();
        end
        checkOutput("cnt_invalid_hold", 64'(m.stall_cnt), 64'd5);

        // Saturation on the 4-bit counter build.
        @(negedge clk); idleInputs();
        m4.ID_valid_a = 1; m4.EX_stall = 1;
        repeat (20) @(negedge clk);
        checkOutput("cnt4_saturate", 64'(m4.stall_cnt), 64'd15);
        idleInputs4();

        // Reset dropped between edges with r4 and r5 outstanding.
        @(negedge clk); idleInputs();
        m.ID_valid_a = 1; m.ID_rf_we_a = 1; m.ID_long_a = 1; m.ID_rf_waddr_a = 4;
        m.ID_valid_b = 1; m.ID_rf_we_b = 1; m.ID_long_b = 1; m.ID_rf_waddr_b = 5;
        applyStimulus();
        checkOutput("pre_rst_vec", 64'(m.pending_vec), 64'h30);
        @(negedge clk); idleInputs();
        m.ID_valid_a = 1; m.ID_rf_raddr_a1 = 5;
        #1;
        checkOutput("pre_rst_stall", 64'(m.ID_stall), 64'd1);
        rstn = 1'b0;
        modelReset();
        #1;
        checkOutput("async_rst_vec", 64'(m.pending_vec), 64'd0);
        checkOutput("async_rst_stall", 64'(m.ID_stall), 64'd0);
        #1;
        rstn = 1'b1;

        for (int i = 0; i < 400; i++) randomCycle();

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
